v3a_fifo_rr_controller: RTL and testbench

//  Round-robin arbiter and occupancy controller for a v3a_SyncFifo instance.

---
 rtl/v3a_fifo_rr_controller.sv | 115 +++++++++++
 tb/tb_v3a_fifo_rr_controller.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/v3a_fifo_rr_controller.sv
// Round-robin write-port arbiter and occupancy tracker for a v3a_SyncFifo.
// The FIFO itself has no full/empty logic; this block is the only thing that
// keeps it from overflowing or underflowing. Grant is combinational off the
// current round-robin start index, and count tracks the FIFO occupancy.

module v3a_fifo_rr_controller #(
  parameter int unsigned p_num_reqs    = 4,
  parameter int unsigned p_num_entries = 8,
  parameter int unsigned p_bit_width   = 32,
  localparam int unsigned CW = $clog2(p_num_entries) + 1,
  localparam int unsigned GW = (p_num_reqs > 1) ? $clog2(p_num_reqs) : 1
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic [p_num_reqs*p_bit_width-1:0] req_msg,
  input  logic [p_num_reqs-1:0]             req_val,
  output logic [p_num_reqs-1:0]             req_rdy,
  output logic                              fifo_write_en,
  output logic [p_bit_width-1:0]            fifo_write_msg,
  output logic                              fifo_read_adv,
  output logic                              deq_val,
  input  logic                              deq_rdy,
  output logic [CW-1:0]                     count,
  output logic                              full,
  output logic                              empty,
  output logic [GW-1:0]                     grant_id
);

  localparam logic [CW-1:0] MaxCount = CW'(p_num_entries);
  localparam logic [GW-1:0] LastReq  = GW'(p_num_reqs - 1);

  logic [CW-1:0]          count_q, count_d;
  logic [GW-1:0]          prio_q, prio_d;
  logic [GW-1:0]          winner;
  logic                   found;
  int unsigned            cand;
  logic                   space;
  logic                   enq;
  logic                   deq;
  logic [p_bit_width-1:0] winner_msg;

  // Rotating-priority scan: first valid requester at or after prio_q wins.
  always_comb begin
    winner = '0;
    found  = 1'b0;
    cand   = 0;
    for (int unsigned k = 0; k < p_num_reqs; k++) begin
      cand = 32'(prio_q) + k;
      if (cand >= p_num_reqs) begin
        cand = cand - p_num_reqs;
      end
      for (int unsigned i = 0; i < p_num_reqs; i++) begin
        if (!found && (cand == i) && req_val[i]) begin
          found  = 1'b1;
          winner = GW'(i);
        end
      end
    end
  end

  // Mux the winner's message slice with constant part-selects only.
  always_comb begin
    winner_msg = '0;
    for (int unsigned i = 0; i < p_num_reqs; i++) begin
      if (winner == GW'(i)) begin
        winner_msg = req_msg[i*p_bit_width +: p_bit_width];
      end
    end
  end

  // Handshake decode. Everything is forced quiet while reset is held low, so
  // the producers and the FIFO see no activity even though reset is async.
  always_comb begin
    space = (count_q < MaxCount);
    // Enqueue never looks at deq_rdy: a full FIFO blocks even if it pops now.
    enq   = reset && space && found;
    deq   = reset && (count_q != '0) && deq_rdy;

    req_rdy = '0;
    for (int unsigned i = 0; i < p_num_reqs; i++) begin
      req_rdy[i] = enq && (winner == GW'(i));
    end

    fifo_write_en  = enq;
    fifo_write_msg = enq ? winner_msg : '0;
    fifo_read_adv  = deq;
    deq_val        = reset && (count_q != '0);
    grant_id       = enq ? winner : '0;

    count = count_q;
    full  = (count_q == MaxCount);
    empty = (count_q == '0);
  end

  // Next-state: occupancy and round-robin pointer.
  always_comb begin
    count_d = count_q + CW'(enq) - CW'(deq);
    prio_d  = prio_q;
    if (enq) begin
      prio_d = (winner == LastReq) ? '0 : winner + GW'(1);
    end
  end

  // State registers; async clear keeps count aligned with the FIFO pointers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count_q <= '0;
      prio_q  <= '0;
    end else begin
      count_q <= count_d;
      prio_q  <= prio_d;
    end
  end

endmodule

// File: tb/tb_v3a_fifo_rr_controller.sv
// Bench for v3a_fifo_rr_controller: a behavioural FIFO model follows the
// write/pop strobes, and a queue of expected words is checked at each pop.

module tb_v3a_fifo_rr_controller;

  localparam int N = 4;
  localparam int E = 8;
  localparam int W = 32;

  logic           clk = 1'b0;
  logic           reset_n;
  logic [N*W-1:0] req_msg;
  logic [N-1:0]   req_val;
  logic [N-1:0]   req_rdy;
  logic           fifo_write_en;
  logic [W-1:0]   fifo_write_msg;
  logic           fifo_read_adv;
  logic           deq_val;
  logic           deq_rdy;
  logic [3:0]     count;
  logic           full;
  logic           empty;
  logic [1:0]     grant_id;

  int checks = 0;
  int errors = 0;

  logic [W-1:0] exp_q[$];
  logic [W-1:0] mem[E];
  logic [2:0]   wptr, rptr;
  logic [W-1:0] head;
  logic [W-1:0] exp_w;

  always #5 clk = ~clk;

  v3a_fifo_rr_controller #(
    .p_num_reqs   (N),
    .p_num_entries(E),
    .p_bit_width  (W)
  ) dut (
    .clk           (clk),
    .reset         (reset_n),
    .req_msg       (req_msg),
    .req_val       (req_val),
    .req_rdy       (req_rdy),
    .fifo_write_en (fifo_write_en),
    .fifo_write_msg(fifo_write_msg),
    .fifo_read_adv (fifo_read_adv),
    .deq_val       (deq_val),
    .deq_rdy       (deq_rdy),
    .count         (count),
    .full          (full),
    .empty         (empty),
    .grant_id      (grant_id)
  );

  // Behavioural stand-in for the FIFO storage, driven by the DUT strobes.
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (fifo_write_en) begin
        mem[wptr] <= fifo_write_msg;
        wptr      <= wptr + 3'd1;
      end
      if (fifo_read_adv) rptr <= rptr + 3'd1;
    end
  end
  assign head = mem[rptr];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_msg(input int i, input logic [W-1:0] v);
    req_msg[i*W +: W] = v;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    req_val = '0;
    deq_rdy = 1'b0;
    req_msg = '0;
    exp_q.delete();
    tick();
    reset_n = 1'b1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    req_val = 4'hF;
    req_msg = {32'h33, 32'h22, 32'h11, 32'h00};
    deq_rdy = 1'b1;
    @(negedge clk);
    @(negedge clk);
    checks++; if (req_rdy !== 4'b0) begin errors++; $display("FAIL rst_req_rdy got %b want 0000", req_rdy); end
    checks++; if (fifo_write_en !== 1'b0) begin errors++; $display("FAIL rst_wen got %b want 0", fifo_write_en); end
    checks++; if (fifo_write_msg !== 32'h0) begin errors++; $display("FAIL rst_wmsg got %h want 0", fifo_write_msg); end
    checks++; if (fifo_read_adv !== 1'b0) begin errors++; $display("FAIL rst_radv got %b want 0", fifo_read_adv); end
    checks++; if (grant_id !== 2'd0) begin errors++; $display("FAIL rst_gid got %0d want 0", grant_id); end
    checks++; if ({empty, full, deq_val} !== 3'b100) begin errors++; $display("FAIL rst_flags got e%b f%b v%b want e1 f0 v0", empty, full, deq_val); end
    req_val = '0;
    deq_rdy = 1'b0;
    tick();
    reset_n = 1'b1;
    @(negedge clk);
    checks++; if (count !== 4'd0) begin errors++; $display("FAIL idle_count got %0d want 0", count); end
    checks++; if ({empty, full, deq_val} !== 3'b100) begin errors++; $display("FAIL idle_flags got e%b f%b v%b want e1 f0 v0", empty, full, deq_val); end
    checks++; if (req_rdy !== 4'b0) begin errors++; $display("FAIL idle_req_rdy got %b want 0000", req_rdy); end
  endtask

  task automatic test_async_reset();
    do_reset();
    req_val = 4'b0001;
    for (int i = 0; i < 5; i++) begin
      set_msg(0, 32'hC0 + i);
      tick();
    end
    req_val = '0;
    @(negedge clk);
    checks++; if (count !== 4'd5) begin errors++; $display("FAIL pre_async_count got %0d want 5", count); end
    #2 reset_n = 1'b0;
    #1;
    checks++; if (count !== 4'd0) begin errors++; $display("FAIL async_count got %0d want 0", count); end
    checks++; if ({empty, deq_val} !== 2'b10) begin errors++; $display("FAIL async_flags got e%b v%b want e1 v0", empty, deq_val); end
    exp_q.delete();
    #1 reset_n = 1'b1;
  endtask

  task automatic test_single_producer();
    do_reset();
    req_val = 4'b0100;
    for (int i = 0; i < E; i++) begin
      set_msg(2, 32'hA0 + i);
      @(negedge clk);
      checks++; if (req_rdy !== 4'b0100) begin errors++; $display("FAIL sp_rdy[%0d] got %b want 0100", i, req_rdy); end
      checks++; if (fifo_write_msg !== 32'hA0 + i) begin errors++; $display("FAIL sp_wmsg[%0d] got %h want %h", i, fifo_write_msg, 32'hA0 + i); end
      exp_q.push_back(32'hA0 + i);
      tick();
    end
    set_msg(2, 32'hA8);
    @(negedge clk);
    checks++; if ({full, count} !== {1'b1, 4'd8}) begin errors++; $display("FAIL sp_full got f%b c%0d want f1 c8", full, count); end
    checks++; if ({req_rdy, fifo_write_en} !== 5'b0) begin errors++; $display("FAIL sp_held got rdy %b wen %b want 0000 0", req_rdy, fifo_write_en); end
    tick();
    req_val = '0;
    deq_rdy = 1'b1;
    for (int i = 0; i < E; i++) begin
      @(negedge clk);
      exp_w = exp_q.pop_front();
      checks++; if ({deq_val, fifo_read_adv} !== 2'b11) begin errors++; $display("FAIL sp_pop_val[%0d] got %b want 11", i, {deq_val, fifo_read_adv}); end
      checks++; if (head !== exp_w) begin errors++; $display("FAIL sp_pop[%0d] got %h want %h", i, head, exp_w); end
      tick();
    end
    @(negedge clk);
    checks++; if ({empty, count, fifo_read_adv} !== {1'b1, 4'd0, 1'b0}) begin errors++; $display("FAIL sp_empty got e%b c%0d adv%b want e1 c0 adv0", empty, count, fifo_read_adv); end
    tick();
    checks++; if (count !== 4'd0) begin errors++; $display("FAIL sp_empty_deq got %0d want 0", count); end
    deq_rdy = 1'b0;
  endtask

  task automatic test_fairness();
    do_reset();
    for (int i = 0; i < N; i++) set_msg(i, 32'h10 * i);
    req_val = 4'hF;
    deq_rdy = 1'b1;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      checks++; if (grant_id !== 2'(k % N)) begin errors++; $display("FAIL rr_gid[%0d] got %0d want %0d", k, grant_id, k % N); end
      checks++; if (fifo_write_msg !== 32'h10 * (k % N)) begin errors++; $display("FAIL rr_wmsg[%0d] got %h want %h", k, fifo_write_msg, 32'h10 * (k % N)); end
      if (k > 0) begin
        exp_w = exp_q.pop_front();
        checks++; if (head !== exp_w) begin errors++; $display("FAIL rr_pop[%0d] got %h want %h", k, head, exp_w); end
        checks++; if (count !== 4'd1) begin errors++; $display("FAIL rr_count[%0d] got %0d want 1", k, count); end
      end
      exp_q.push_back(32'h10 * (k % N));
      tick();
    end
    req_val = '0;
    @(negedge clk);
    exp_w = exp_q.pop_front();
    checks++; if (head !== exp_w) begin errors++; $display("FAIL rr_last got %h want %h", head, exp_w); end
    tick();
    checks++; if (count !== 4'd0) begin errors++; $display("FAIL rr_drain got %0d want 0", count); end
  endtask

  task automatic test_sparse_rr();
    logic [1:0] order [3];
    order[0] = 2'd3; order[1] = 2'd0; order[2] = 2'd3;
    // One grant to requester 0 leaves the start index at 1.
    deq_rdy = 1'b0;
    req_val = 4'b0001;
    set_msg(0, 32'h40);
    set_msg(3, 32'h43);
    @(negedge clk);
    checks++; if (grant_id !== 2'd0) begin errors++; $display("FAIL sr_setup got %0d want 0", grant_id); end
    exp_q.push_back(32'h40);
    tick();
    req_val = 4'b1001;
    deq_rdy = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      checks++; if (grant_id !== order[k]) begin errors++; $display("FAIL sr_gid[%0d] got %0d want %0d", k, grant_id, order[k]); end
      exp_w = exp_q.pop_front();
      checks++; if (head !== exp_w) begin errors++; $display("FAIL sr_pop[%0d] got %h want %h", k, head, exp_w); end
      exp_q.push_back(32'h40 + 32'(order[k]));
      tick();
    end
    req_val = '0;
    @(negedge clk);
    exp_w = exp_q.pop_front();
    checks++; if (head !== exp_w) begin errors++; $display("FAIL sr_last got %h want %h", head, exp_w); end
    tick();
    deq_rdy = 1'b0;
  endtask

  task automatic test_full_deq();
    do_reset();
    req_val = 4'b0010;
    for (int i = 0; i < E; i++) begin
      set_msg(1, 32'hB0 + i);
      exp_q.push_back(32'hB0 + i);
      tick();
    end
    set_msg(1, 32'h99);
    deq_rdy = 1'b1;
    @(negedge clk);
    checks++; if ({req_rdy, fifo_write_en, fifo_read_adv} !== 6'b000001) begin errors++; $display("FAIL fd_block got rdy %b wen %b adv %b want 0000 0 1", req_rdy, fifo_write_en, fifo_read_adv); end
    exp_w = exp_q.pop_front();
    checks++; if (head !== exp_w) begin errors++; $display("FAIL fd_pop0 got %h want %h", head, exp_w); end
    tick();
    @(negedge clk);
    checks++; if (count !== 4'd7) begin errors++; $display("FAIL fd_count7 got %0d want 7", count); end
    checks++; if ({req_rdy, fifo_write_msg} !== {4'b0010, 32'h99}) begin errors++; $display("FAIL fd_enq got rdy %b msg %h want 0010 99", req_rdy, fifo_write_msg); end
    exp_w = exp_q.pop_front();
    exp_q.push_back(32'h99);
    tick();
    checks++; if (count !== 4'd7) begin errors++; $display("FAIL fd_hold7 got %0d want 7", count); end
    req_val = '0;
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      exp_w = exp_q.pop_front();
      checks++; if (head !== exp_w) begin errors++; $display("FAIL fd_drain[%0d] got %h want %h", i, head, exp_w); end
      tick();
    end
    checks++; if (empty !== 1'b1) begin errors++; $display("FAIL fd_empty got %b want 1", empty); end
    deq_rdy = 1'b0;
  endtask

  task automatic test_empty_enq();
    req_val = 4'b0001;
    set_msg(0, 32'h55);
    deq_rdy = 1'b0;
    @(negedge clk);
    checks++; if ({fifo_write_en, deq_val} !== 2'b10) begin errors++; $display("FAIL ee_bypass got wen %b val %b want 1 0", fifo_write_en, deq_val); end
    exp_q.push_back(32'h55);
    tick();
    req_val = '0;
    deq_rdy = 1'b1;
    @(negedge clk);
    exp_w = exp_q.pop_front();
    checks++; if ({deq_val, fifo_read_adv, count} !== {2'b11, 4'd1}) begin errors++; $display("FAIL ee_visible got val %b adv %b c%0d want 1 1 1", deq_val, fifo_read_adv, count); end
    checks++; if (head !== exp_w) begin errors++; $display("FAIL ee_head got %h want %h", head, exp_w); end
    tick();
    checks++; if ({count, empty} !== {4'd0, 1'b1}) begin errors++; $display("FAIL ee_done got c%0d e%b want c0 e1", count, empty); end
    deq_rdy = 1'b0;
  endtask

  initial begin
    test_reset();
    test_async_reset();
    test_single_producer();
    test_fairness();
    test_sparse_rr();
    test_full_deq();
    test_empty_enq();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
